// File: rtl/gb_dma_if.sv
// ----------------------------------------------------------------------------
// gb_dma_if
//   Memory strobe bundle shared between the CPU side of the Game Boy bus and
//   the OAM DMA engine. The multiplexed address/data buses are bidirectional
//   nets and are carried as plain inout ports on the engine itself, so this
//   bundle holds only the single-driver strobes.
//
//   mem_we           CPU memory write strobe (CPU -> DMA)
//   mem_re           CPU memory read strobe  (CPU -> DMA)
//   dma_mem_re       DMA read strobe, ORed with mem_re at the decoders
//   dma_mem_we       DMA write strobe, ORed with mem_we at the decoders
//   cpu_mem_disable  high while a transfer owns the bus; stalls the CPU
//
//   master : the CPU / bus side
//   slave  : the DMA engine
// ----------------------------------------------------------------------------
interface gb_dma_if;
    logic mem_we;
    logic mem_re;
    logic dma_mem_re;
    logic dma_mem_we;
    logic cpu_mem_disable;

    modport master (
        output mem_we,
        output mem_re,
        input  dma_mem_re,
        input  dma_mem_we,
        input  cpu_mem_disable
    );

    modport slave (
        input  mem_we,
        input  mem_re,
        output dma_mem_re,
        output dma_mem_we,
        output cpu_mem_disable
    );
endinterface

// File: rtl/gb_dma.sv
// ----------------------------------------------------------------------------
// gb_dma
//   Game Boy OAM DMA engine. A CPU write to the DMA register starts a copy of
//   XFER_LEN bytes from {src_hi, 8'h00} upward into OAM at OAM_BASE. Each byte
//   takes three cycles: present the source address (RAM latency), capture the
//   read data, then write it to OAM. While busy the engine masters the address
//   and data buses and stalls the CPU through cpu_mem_disable.
//
// Ports
//   clock          system clock, all state on the rising edge
//   reset          asynchronous, active-low
//   addr_ext       16-bit address bus; driven only while a transfer runs
//   data_ext       8-bit data bus; driven in the write phase and on register
//                  readback, high-impedance otherwise
//   bus            strobe bundle (gb_dma_if.slave)
//   dma_chipscope  debug view {state[1:0], idx[5:0]}
// ----------------------------------------------------------------------------
module gb_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter int unsigned XFER_LEN     = 160
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [15:0] addr_ext,
    inout  wire  [7:0]  data_ext,
    gb_dma_if.slave     bus,
    output logic [7:0]  dma_chipscope
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    // Encoding is visible on dma_chipscope[7:6], so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_ADDR = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_WRITE   = 2'd3
    } state_e;

    state_e     state_q,  state_d;
    logic [7:0] src_hi_q, src_hi_d;
    logic [7:0] idx_q,    idx_d;
    logic [7:0] buf_q,    buf_d;

    logic        addr_oe;
    logic [15:0] addr_drv;
    logic        data_oe;
    logic [7:0]  data_drv;
    logic        dma_re;
    logic        dma_we;

    logic reg_hit;
    assign reg_hit = (addr_ext == DMA_REG_ADDR);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d  = state_q;
        src_hi_d = src_hi_q;
        idx_d    = idx_q;
        buf_d    = buf_q;

        case (state_q)
            ST_IDLE: begin
                // Only an idle engine accepts a start; writes to the register
                // during a transfer cannot reach here and are dropped.
                if (bus.mem_we && reg_hit) begin
                    src_hi_d = data_ext;
                    idx_d    = 8'd0;
                    state_d  = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                buf_d   = data_ext;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == LAST_IDX) ? ST_IDLE : ST_RD_ADDR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            src_hi_q <= 8'h00;
            idx_q    <= 8'h00;
            buf_q    <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q  <= state_d;
            src_hi_q <= src_hi_d;
            idx_q    <= idx_d;
            buf_q    <= buf_d;
        end
    end

    // ------------------------------------------------------------------------
    // Bus decode: purely from the current state so strobes and drives are
    // valid in the same cycle a state is entered.
    // ------------------------------------------------------------------------
    always_comb begin
        addr_oe  = 1'b0;
        addr_drv = 16'h0000;
        data_oe  = 1'b0;
        data_drv = 8'h00;
        dma_re   = 1'b0;
        dma_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Register readback; a simultaneous write takes precedence.
                if (bus.mem_re && !bus.mem_we && reg_hit) begin
                    data_oe  = 1'b1;
                    data_drv = src_hi_q;
                end
            end
            ST_RD_ADDR, ST_RD_DATA: begin
                // Low byte stays below 8'hA0, so the page never carries and
                // the source page is used exactly as written.
                addr_oe  = 1'b1;
                addr_drv = {src_hi_q, idx_q};
                dma_re   = 1'b1;
            end
            ST_WRITE: begin
                addr_oe  = 1'b1;
                addr_drv = OAM_BASE + {8'h00, idx_q};
                data_oe  = 1'b1;
                data_drv = buf_q;
                dma_we   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign addr_ext = addr_oe ? addr_drv : 16'hzzzz;
    assign data_ext = data_oe ? data_drv : 8'hzz;

    assign bus.dma_mem_re      = dma_re;
    assign bus.dma_mem_we      = dma_we;
    assign bus.cpu_mem_disable = (state_q != ST_IDLE);

    assign dma_chipscope = {2'(state_q), idx_q[5:0]};

endmodule

// File: tb/tb_gb_dma.sv
// ----------------------------------------------------------------------------
// tb_gb_dma
//   Bench for gb_dma: a CPU driver, a synchronous 64 KiB memory on the shared
//   bus, and a behavioural model that tracks the transfer as a cycle count
//   since the start write. Expected bus activity is derived from that count:
//   byte = t / 3, phase = t % 3.
// ----------------------------------------------------------------------------
module tb_gb_dma;

    localparam logic [15:0] REG_ADDR = 16'hFF46;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    wire  [15:0] addr_ext;
    wire  [7:0]  data_ext;
    logic [7:0]  dma_chipscope;

    gb_dma_if bus_if ();

    gb_dma dut (
        .clock         (clock),
        .reset         (reset),
        .addr_ext      (addr_ext),
        .data_ext      (data_ext),
        .bus           (bus_if.slave),
        .dma_chipscope (dma_chipscope)
    );

    // ------------------------------------------------------------------------
    // CPU side drivers
    // ------------------------------------------------------------------------
    logic        cpu_addr_oe = 1'b0;
    logic [15:0] cpu_addr    = 16'h0000;
    logic        cpu_data_oe = 1'b0;
    logic [7:0]  cpu_data    = 8'h00;

    assign addr_ext = cpu_addr_oe ? cpu_addr : 16'hzzzz;
    assign data_ext = cpu_data_oe ? cpu_data : 8'hzz;

    // ------------------------------------------------------------------------
    // Synchronous memory: one cycle read latency, data driven only while a
    // read strobe is still active. CPU strobes are gated by the stall.
    // ------------------------------------------------------------------------
    logic [7:0]  mem [0:65535];
    logic [7:0]  rd_q    = 8'h00;
    logic        rd_oe_q = 1'b0;
    logic        pl_en   = 1'b0;
    logic [15:0] pl_addr = 16'h0000;
    logic [7:0]  pl_data = 8'h00;

    wire re_any = bus_if.dma_mem_re | (bus_if.mem_re & ~bus_if.cpu_mem_disable);
    wire we_any = bus_if.dma_mem_we | (bus_if.mem_we & ~bus_if.cpu_mem_disable);

    assign data_ext = (rd_oe_q && re_any) ? rd_q : 8'hzz;

    always @(posedge clock) begin
        rd_q    <= mem[addr_ext];
        rd_oe_q <= re_any && (addr_ext != REG_ADDR);
        if (pl_en)       mem[pl_addr]  <= pl_data;
        else if (we_any) mem[addr_ext] <= data_ext;
    end

    // Source contents as loaded by the bench (never written by the bus).
    logic [7:0] golden [0:65535];

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: m_t = cycles since start (-1 when idle)
    // ------------------------------------------------------------------------
    int         m_t    = -1;
    logic [7:0] m_src  = 8'h00;
    int         m_done = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_t    = -1;
            m_src  = 8'h00;
            m_done = 0;
        end else if (m_t < 0) begin
            if (bus_if.mem_we && addr_ext == REG_ADDR) begin
                m_src  = data_ext;
                m_t    = 0;
                m_done = 0;
            end
        end else begin
            m_t = m_t + 1;
            if (m_t == 480) begin
                m_t    = -1;
                m_done = 160;
            end
        end
    end

    int   c_byte;
    int   c_ph;
    logic c_busy;

    always @(negedge clock) begin
        if (reset) begin
            c_busy = (m_t >= 0);
            c_byte = c_busy ? m_t / 3 : 0;
            c_ph   = c_busy ? m_t % 3 : 0;
            check("busy", bus_if.cpu_mem_disable, c_busy);
            check("dma_re", bus_if.dma_mem_re, c_busy && c_ph < 2);
            check("dma_we", bus_if.dma_mem_we, c_busy && c_ph == 2);
            if (c_busy) begin
                check("scope", dma_chipscope, {2'(c_ph + 1), 6'(c_byte)});
                if (c_ph < 2) begin
                    check("rd_addr", addr_ext, {m_src, 8'(c_byte)});
                end else begin
                    check("wr_addr", addr_ext, 16'hFE00 + 16'(c_byte));
                    check("wr_data", data_ext, golden[{m_src, 8'(c_byte)}]);
                end
            end else begin
                check("scope_idle", dma_chipscope, {2'b00, 6'(m_done)});
                if (bus_if.mem_re && !bus_if.mem_we && addr_ext == REG_ADDR)
                    check("readback", data_ext, m_src);
            end
        end
    end

    int busy_total = 0;
    always @(negedge clock) if (bus_if.cpu_mem_disable) busy_total++;

    // ------------------------------------------------------------------------
    // Tasks
    // ------------------------------------------------------------------------
    task automatic preload(input logic [7:0] page, input bit pattern);
        logic [7:0] v;
        for (int i = 0; i < 160; i++) begin
            v = pattern ? (8'(i) ^ 8'h5A) : 8'($urandom);
            golden[{page, 8'(i)}] = v;
            @(posedge clock); #1;
            pl_en   = 1'b1;
            pl_addr = {page, 8'(i)};
            pl_data = v;
        end
        @(posedge clock); #1;
        pl_en = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge clock); #1;
        cpu_addr_oe   = 1'b1;
        cpu_addr      = a;
        cpu_data_oe   = 1'b1;
        cpu_data      = d;
        bus_if.mem_we = 1'b1;
        @(posedge clock); #1;
        cpu_addr_oe   = 1'b0;
        cpu_data_oe   = 1'b0;
        bus_if.mem_we = 1'b0;
    endtask

    task automatic cpu_read_check(input logic [15:0] a, input logic [7:0] exp, input string name);
        @(posedge clock); #1;
        cpu_addr_oe   = 1'b1;
        cpu_addr      = a;
        bus_if.mem_re = 1'b1;
        @(negedge clock);
        check(name, data_ext, exp);
        @(posedge clock); #1;
        cpu_addr_oe   = 1'b0;
        bus_if.mem_re = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 700 && !done; i++) begin
            @(negedge clock);
            if (!bus_if.cpu_mem_disable) done = 1'b1;
        end
        check({name, "_finished"}, done, 1);
    endtask

    task automatic check_oam(input logic [7:0] page, input string name);
        int bad = 0;
        for (int i = 0; i < 160; i++)
            if (mem[16'hFE00 + 16'(i)] !== golden[{page, 8'(i)}]) bad++;
        check(name, bad, 0);
    endtask

    task automatic run_copy(input logic [7:0] page, input string name);
        int start;
        start = busy_total;
        cpu_write(REG_ADDR, page);
        wait_idle(name);
        check({name, "_busy_cycles"}, busy_total - start, 480);
        check_oam(page, {name, "_oam"});
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int bad;
        bit found;
        logic [7:0] page;

        bus_if.mem_we = 1'b0;
        bus_if.mem_re = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_busy",  bus_if.cpu_mem_disable, 0);
        check("rst_re",    bus_if.dma_mem_re, 0);
        check("rst_we",    bus_if.dma_mem_we, 0);
        check("rst_scope", dma_chipscope, 8'h00);
        reset = 1'b1;

        preload(8'hC0, 1'b1);
        preload(8'hD0, 1'b0);
        preload(8'h80, 1'b0);

        // Basic copy with hand-computed timing of byte 0
        start = busy_total;
        cpu_write(REG_ADDR, 8'hC0);
        @(negedge clock);
        check("b0_rdaddr_addr", addr_ext, 16'hC000);
        check("b0_rdaddr_re",   bus_if.dma_mem_re, 1);
        check("b0_rdaddr_we",   bus_if.dma_mem_we, 0);
        @(negedge clock);
        check("b0_rddata_addr", addr_ext, 16'hC000);
        check("b0_rddata_re",   bus_if.dma_mem_re, 1);
        @(negedge clock);
        check("b0_write_addr",  addr_ext, 16'hFE00);
        check("b0_write_we",    bus_if.dma_mem_we, 1);
        check("b0_write_re",    bus_if.dma_mem_re, 0);
        check("b0_write_data",  data_ext, 8'h5A);
        wait_idle("basic");
        check("basic_busy_cycles", busy_total - start, 480);
        bad = 0;
        for (int i = 0; i < 160; i++)
            if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h5A)) bad++;
        check("basic_oam_literal", bad, 0);

        // Readback and a write to a neighbouring register
        cpu_read_check(REG_ADDR, 8'hC0, "readback_c0");
        cpu_write(16'hFF45, 8'h12);
        repeat (4) begin
            @(negedge clock);
            check("ff45_no_start", bus_if.cpu_mem_disable, 0);
        end
        cpu_read_check(REG_ADDR, 8'hC0, "readback_after_ff45");

        // Random source pages
        for (int n = 0; n < 3; n++) begin
            page = 8'($urandom_range(0, 63));
            preload(page, 1'b0);
            run_copy(page, "random");
        end

        // Start writes during a transfer are dropped
        start = busy_total;
        cpu_write(REG_ADDR, 8'hC0);
        for (int n = 0; n < 4; n++) begin
            repeat ($urandom_range(20, 90)) @(posedge clock);
            #1;
            cpu_data_oe   = 1'b0;
            bus_if.mem_we = 1'b1;
            @(posedge clock); #1;
            bus_if.mem_we = 1'b0;
        end
        wait_idle("ignore");
        check("ignore_busy_cycles", busy_total - start, 480);
        check_oam(8'hC0, "ignore_oam");
        cpu_read_check(REG_ADDR, 8'hC0, "readback_after_ignore");

        // Last byte then immediate retrigger
        page = 8'($urandom_range(0, 63));
        preload(page, 1'b0);
        cpu_write(REG_ADDR, page);
        found = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
            @(negedge clock);
            if (bus_if.dma_mem_we && addr_ext == 16'hFE9F) found = 1'b1;
        end
        check("last_write_seen", found, 1);
        check("last_scope", dma_chipscope, 8'hDF);
        cpu_write(REG_ADDR, 8'h80);
        wait_idle("retrigger");
        check_oam(8'h80, "retrigger_oam");
        cpu_read_check(REG_ADDR, 8'h80, "readback_80");

        // Reset in the middle of a transfer
        cpu_write(REG_ADDR, 8'hD0);
        repeat ($urandom_range(10, 400)) @(negedge clock);
        #2;
        reset       = 1'b0;
        cpu_addr_oe = 1'b1;
        cpu_addr    = 16'h1234;
        #1;
        check("midrst_busy",  bus_if.cpu_mem_disable, 0);
        check("midrst_re",    bus_if.dma_mem_re, 0);
        check("midrst_we",    bus_if.dma_mem_we, 0);
        check("midrst_scope", dma_chipscope, 8'h00);
        check("midrst_addr_released", addr_ext, 16'h1234);
        @(negedge clock);
        cpu_addr_oe = 1'b0;
        reset       = 1'b1;
        cpu_read_check(REG_ADDR, 8'h00, "readback_after_reset");
        run_copy(8'hD0, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
